fb_rect_writer: RTL
===================

# fb_rect_writer

Drawing engine directly upstream of the 120×60 3-bit frame buffer: accepts rectangle-fill and full-clear commands and drives the buffer's write port (wr/addr/di) one pixel per clock, row-major, with clipping at the screen edge. Game logic issues commands through a valid/ready handshake. The frame buffer's read ports feed display scan-out and are unaffected.

## Interface
Parameters:
- FB_W, 120, frame width in pixels
- FB_H, 60, frame height in pixels
- AW, 16, frame-buffer address width
- CW, 3, colour width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle and able to accept a command
- cmd_op  in  1  0 = fill rectangle, 1 = clear whole frame
- cmd_x  in  7  rectangle left column
- cmd_y  in  6  rectangle top row
- cmd_w  in  7  rectangle width in pixels
- cmd_h  in  6  rectangle height in pixels
- cmd_color  in  CW  fill colour (ignored for clear)
- wr  out  1  frame-buffer write strobe
- addr  out  AW  frame-buffer write address = row*FB_W + col
- di  out  CW  frame-buffer write data
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on command completion

## Operation
- States: IDLE, SETUP, FILL, DONE.
- IDLE: cmd_ready=1, busy=0. A command is accepted on a rising edge with cmd_valid && cmd_ready; fields are latched and the state moves to SETUP. cmd_valid outside IDLE is ignored.
- Clear is treated as fill with x=0, y=0, w=FB_W, h=FB_H, colour 0.
- SETUP computes the clipped extent: x_end = min(x+w, FB_W), y_end = min(y+h, FB_H), using 8-bit sums with no overflow. If w==0, h==0, x>=FB_W or y>=FB_H, the extent is empty and the state goes directly to DONE. Otherwise it loads col=x, row=y, row_base=y*FB_W and goes to FILL.
- The y*FB_W product is formed once in SETUP by shift-add (120 = 128−8). During FILL the address is maintained incrementally: addr+1 within a row, and row_base+FB_W plus x at the row change. There is no multiplier in the FILL loop.
- FILL issues one write per cycle (wr=1, addr, di=colour) with no gaps, including across row changes. After the write of (x_end−1, y_end−1) the state goes to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- wr, addr, di, busy and done are registered outputs. cmd_ready is decoded from state==IDLE.
- Reset values: wr=0, addr=0, di=0, busy=0, done=0, cmd_ready=1 (state IDLE).
- Reset mid-operation: wr drops asynchronously and the command is abandoned. There is no done pulse and pixels already written stay written.

## Timing
- Accept edge at cycle T. SETUP is T+1. The first write is presented in cycle T+2.
- N = clipped pixel count. Writes occupy T+2 … T+1+N. done is high in cycle T+2+N. cmd_ready is high from T+3+N.
- Empty extent: no writes, done in T+2.
- busy is high from T+1 through the last write cycle.
- Clear: 7200 writes, addresses 0…7199 in order, done at T+7202.

## Structure
- Shared package fb_pkg: FB_W, FB_H, FB_SIZE=7200, AW, CW, opcode constants OP_FILL/OP_CLEAR, state enum. The frame-buffer and scan-out blocks also use this package.
- One sub-module, fb_rect_clip: combinational clip producing x_end, y_end, empty and row_base from the latched command.

## Test plan
- Fill x=2,y=3,w=4,h=2,colour=5 -> 8 writes, addr 362,363,364,365,482,483,484,485, di=5, with no gap between 365 and 482. done at T+10.
- Clip: x=118,y=59,w=5,h=5,colour=7 -> exactly 2 writes, addr 7198 and 7199. done at T+4.
- Empty: w=0 (and separately x=120) -> no wr. done at T+2. cmd_ready high at T+3.
- Clear -> 7200 consecutive writes, addr 0…7199, di=0. done at T+7202.
- Handshake: hold cmd_valid high with a second command during a fill -> second command accepted only on the first edge after done. Its first write appears 2 cycles after that edge.
- Reset asserted after the 10th write of a clear -> wr=0 immediately, busy=0, done never pulses, cmd_ready=1 after reset release. A new fill then behaves normally.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg
// Shared definitions for the 120x60 3-bit frame buffer: geometry, address and
// colour widths, command opcodes, the drawing-engine state encoding, and the
// row-base helper used by the rectangle clipper.
package fb_pkg;

    localparam int FB_W    = 120;
    localparam int FB_H    = 60;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int AW      = 16;
    localparam int CW      = 3;

    localparam logic OP_FILL  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fb_state_e;

    // y*120 as (y<<7) - (y<<3). This keeps the only multiply out of the fill
    // loop and makes it a single subtract.
    function automatic logic [15:0] row_base_of(input logic [5:0] y);
        return {3'b000, y, 7'b0000000} - {7'b0000000, y, 3'b000};
    endfunction

endpackage

// File: rtl/fb_rect_clip.sv
// fb_rect_clip
// Combinational clipper for a latched rectangle command.
//   x, y      : top-left corner (column, row)
//   w, h      : requested size in pixels
//   x_end     : exclusive right column, min(x+w, FB_W)
//   y_end     : exclusive bottom row,   min(y+h, FB_H)
//   empty     : nothing to draw (zero size or origin off-screen)
//   row_base  : y*FB_W, the address of column 0 on the top row
module fb_rect_clip #(
    parameter int FB_W = fb_pkg::FB_W,
    parameter int FB_H = fb_pkg::FB_H,
    parameter int AW   = fb_pkg::AW
) (
    input  logic [6:0]    x,
    input  logic [5:0]    y,
    input  logic [6:0]    w,
    input  logic [5:0]    h,
    output logic [7:0]    x_end,
    output logic [7:0]    y_end,
    output logic          empty,
    output logic [AW-1:0] row_base
);
    import fb_pkg::row_base_of;

    logic [7:0] x_sum_s;
    logic [7:0] y_sum_s;

    // 8-bit sums cannot overflow: 127+127 and 63+63 both fit
    always_comb begin
        x_sum_s = {1'b0, x} + {1'b0, w};
        y_sum_s = {2'b00, y} + {2'b00, h};

        if (x_sum_s > 8'(FB_W)) begin
            x_end = 8'(FB_W);
        end else begin
            x_end = x_sum_s;
        end

        if (y_sum_s > 8'(FB_H)) begin
            y_end = 8'(FB_H);
        end else begin
            y_end = y_sum_s;
        end

        empty = (w == 7'd0) || (h == 6'd0) ||
                ({1'b0, x} >= 8'(FB_W)) || ({2'b00, y} >= 8'(FB_H));

        // row_base_of() hard-codes 120 as 128-8; it only matches FB_W=120
        row_base = AW'(row_base_of(y));
    end

endmodule

// File: rtl/fb_rect_writer.sv
// fb_rect_writer
// Drawing engine in front of the frame-buffer write port. It accepts
// rectangle-fill and full-clear commands and writes one pixel per clock in
// row-major order, clipped at the screen edge.
//   clk, rst           : clock, asynchronous active-high reset
//   cmd_valid/ready    : command handshake (ready only while idle)
//   cmd_op             : 0 = fill rectangle, 1 = clear whole frame
//   cmd_x/y/w/h/color  : rectangle and colour (colour ignored for clear)
//   wr, addr, di       : frame-buffer write port (addr = row*FB_W + col)
//   busy               : command in progress (setup through last write)
//   done               : one-cycle pulse when a command completes
module fb_rect_writer #(
    parameter int FB_W = fb_pkg::FB_W,
    parameter int FB_H = fb_pkg::FB_H,
    parameter int AW   = fb_pkg::AW,
    parameter int CW   = fb_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [6:0]    cmd_x,
    input  logic [5:0]    cmd_y,
    input  logic [6:0]    cmd_w,
    input  logic [5:0]    cmd_h,
    input  logic [CW-1:0] cmd_color,
    output logic          wr,
    output logic [AW-1:0] addr,
    output logic [CW-1:0] di,
    output logic          busy,
    output logic          done
);
    import fb_pkg::*;

    fb_state_e     state_r;
    logic [6:0]    x_r;
    logic [5:0]    y_r;
    logic [6:0]    w_r;
    logic [5:0]    h_r;
    logic [CW-1:0] color_r;
    logic [6:0]    col_r;
    logic [5:0]    row_r;
    logic [AW-1:0] row_base_r;

    logic [7:0]    x_end_s;
    logic [7:0]    y_end_s;
    logic          empty_s;
    logic [AW-1:0] row_base_s;
    logic          last_col_s;
    logic          last_row_s;

    fb_rect_clip #(
        .FB_W (FB_W),
        .FB_H (FB_H),
        .AW   (AW)
    ) u_clip (
        .x        (x_r),
        .y        (y_r),
        .w        (w_r),
        .h        (h_r),
        .x_end    (x_end_s),
        .y_end    (y_end_s),
        .empty    (empty_s),
        .row_base (row_base_s)
    );

    // Position of the pixel currently on the write port relative to the clipped extent
    always_comb begin
        last_col_s = ({1'b0, col_r} == (x_end_s - 8'd1));
        last_row_s = ({2'b00, row_r} == (y_end_s - 8'd1));
    end

    assign cmd_ready = (state_r == ST_IDLE);

    // Command FSM and registered write port: accept, set up, walk the rectangle, complete
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            x_r        <= 7'd0;
            y_r        <= 6'd0;
            w_r        <= 7'd0;
            h_r        <= 6'd0;
            color_r    <= {CW{1'b0}};
            col_r      <= 7'd0;
            row_r      <= 6'd0;
            row_base_r <= {AW{1'b0}};
            wr         <= 1'b0;
            addr       <= {AW{1'b0}};
            di         <= {CW{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        // A clear is just a full-screen fill with colour 0
                        if (cmd_op == OP_CLEAR) begin
                            x_r     <= 7'd0;
                            y_r     <= 6'd0;
                            w_r     <= 7'(FB_W);
                            h_r     <= 6'(FB_H);
                            color_r <= {CW{1'b0}};
                        end else begin
                            x_r     <= cmd_x;
                            y_r     <= cmd_y;
                            w_r     <= cmd_w;
                            h_r     <= cmd_h;
                            color_r <= cmd_color;
                        end
                        busy    <= 1'b1;
                        state_r <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (empty_s) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        // First write goes out straight from setup so the
                        // write stream starts the cycle after this one
                        col_r      <= x_r;
                        row_r      <= y_r;
                        row_base_r <= row_base_s;
                        addr       <= row_base_s + AW'(x_r);
                        di         <= color_r;
                        wr         <= 1'b1;
                        state_r    <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    if (last_col_s && last_row_s) begin
                        wr      <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (last_col_s) begin
                        // Row change: next row starts FB_W further on, back at column x
                        col_r      <= x_r;
                        row_r      <= row_r + 6'd1;
                        row_base_r <= row_base_r + AW'(FB_W);
                        addr       <= row_base_r + AW'(FB_W) + AW'(x_r);
                    end else begin
                        col_r <= col_r + 7'd1;
                        addr  <= addr + {{(AW-1){1'b0}}, 1'b1};
                    end
                end

                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    wr      <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
